// File: rtl/sift_pkg.sv
// Shared SIFT pipeline definitions: datapath widths, feedback-loop mode
// constants and the keypoint_counter frame state encoding.
package sift_pkg;

    localparam int CONTRAST_W      = 10;
    localparam int DEFAULT_COORD_W = 10;
    localparam int DEFAULT_CNT_W   = 11;

    // Threshold controller operating modes
    localparam logic HIGH_THROUGHPUT = 1'b0;
    localparam logic HIGH_ACCURACY   = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DRAIN,
        PUBLISH
    } kp_state_e;

    // Magnitude of a signed contrast, one bit wider so |-512| = 512 fits.
    function automatic logic [CONTRAST_W:0] abs_contrast(
        input logic signed [CONTRAST_W-1:0] v
    );
        logic signed [CONTRAST_W:0] w;
        w = CONTRAST_W'(v);
        w = v;
        return v[CONTRAST_W-1] ? (CONTRAST_W+1)'(-w) : (CONTRAST_W+1)'(w);
    endfunction

endpackage

// File: rtl/keypoint_counter_if.sv
// Valid/ready keypoint stream carrying {x, y, contrast}.
//   valid, x, y, contrast : producer -> consumer
//   ready                 : consumer -> producer
// master = producer side, slave = consumer side.
interface keypoint_counter_if
    import sift_pkg::*;
#(
    parameter int COORD_W = DEFAULT_COORD_W
);
    logic                         valid;
    logic                         ready;
    logic        [COORD_W-1:0]    x;
    logic        [COORD_W-1:0]    y;
    logic signed [CONTRAST_W-1:0] contrast;

    modport master (output valid, x, y, contrast, input ready);
    modport slave  (input valid, x, y, contrast, output ready);
endinterface

// File: rtl/keypoint_counter_kp_out_reg.sv
// Valid/ready output register for a keypoint {x, y, contrast}.
//   clk, rst_n     : clock, synchronous active-low reset
//   load           : capture in_* and assert valid on the next edge
//   in_x/in_y/in_contrast : keypoint to capture
//   kp             : downstream stream (master side)
// The caller only asserts load when the register is empty or transferring,
// so a load on a transfer edge simply reloads (1 keypoint/cycle).
module kp_out_reg
    import sift_pkg::*;
#(
    parameter int COORD_W = DEFAULT_COORD_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic        [COORD_W-1:0]    in_x,
    input  logic        [COORD_W-1:0]    in_y,
    input  logic signed [CONTRAST_W-1:0] in_contrast,
    keypoint_counter_if.master           kp
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kp.valid    <= 1'b0;
            kp.x        <= '0;
            kp.y        <= '0;
            kp.contrast <= '0;
        end else if (load) begin
            kp.valid    <= 1'b1;
            kp.x        <= in_x;
            kp.y        <= in_y;
            kp.contrast <= in_contrast;
        end else if (kp.valid && kp.ready) begin
            kp.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/keypoint_counter.sv
// Keypoint counter: filters DoG extremum candidates against a per-frame
// signed contrast threshold, forwards survivors downstream and publishes
// the per-frame keypoint count for the threshold controller.
//   clk, rst_n        : clock, synchronous active-low reset
//   frame_start/end   : one-cycle frame delimiters
//   filter_threshold  : signed threshold, latched on an accepted frame_start
//   cand              : candidate stream in (slave)
//   kp                : keypoint stream out (master)
//   keypoint_num      : saturating count of the last completed frame
//   num_valid         : one-cycle pulse, coincident with a new keypoint_num
module keypoint_counter
    import sift_pkg::*;
#(
    parameter int COORD_W      = DEFAULT_COORD_W,
    parameter int CNT_W        = DEFAULT_CNT_W,
    parameter int KP_RESET_NUM = 750
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         frame_start,
    input  logic                         frame_end,
    input  logic signed [CONTRAST_W-1:0] filter_threshold,
    keypoint_counter_if.slave            cand,
    keypoint_counter_if.master           kp,
    output logic        [CNT_W-1:0]      keypoint_num,
    output logic                         num_valid
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    kp_state_e                    state_q, state_d;
    logic signed [CONTRAST_W-1:0] thr_q;
    logic        [CNT_W-1:0]      count_q;
    logic                         thr_load, cnt_clear;
    logic                         cand_fire, pass, pass_fire, kp_valid_next;
    logic signed [CONTRAST_W+1:0] mag_s, thr_s;

    assign cand.ready = (state_q == COUNT) && (!kp.valid || kp.ready);
    assign cand_fire  = cand.valid && cand.ready;

    // 12-bit signed compare: magnitude is non-negative, so a negative
    // threshold passes every candidate.
    assign mag_s     = $signed({1'b0, abs_contrast(cand.contrast)});
    assign thr_s     = {{2{thr_q[CONTRAST_W-1]}}, thr_q};
    assign pass      = mag_s > thr_s;
    assign pass_fire = cand_fire && pass;

    assign kp_valid_next = pass_fire || (kp.valid && !kp.ready);

    always_comb begin
        state_d   = state_q;
        thr_load  = 1'b0;
        cnt_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    thr_load  = 1'b1;
                    cnt_clear = 1'b1;
                    state_d   = COUNT;
                end
            end
            COUNT: begin
                if (frame_end) begin
                    state_d = kp_valid_next ? DRAIN : PUBLISH;
                end else if (frame_start) begin
                    // Aborted frame: restart counting, nothing published.
                    thr_load  = 1'b1;
                    cnt_clear = 1'b1;
                end
            end
            DRAIN: begin
                if (kp.valid && kp.ready) state_d = PUBLISH;
            end
            PUBLISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            thr_q        <= '0;
            count_q      <= '0;
            keypoint_num <= CNT_W'(KP_RESET_NUM);
            num_valid    <= 1'b0;
        end else begin
            state_q   <= state_d;
            // Count and its strobe are registered together so num_valid
            // always qualifies the freshly published value.
            num_valid <= (state_q == PUBLISH);
            if (state_q == PUBLISH) keypoint_num <= count_q;
            if (thr_load) thr_q <= filter_threshold;
            if (cnt_clear) begin
                count_q <= '0;
            end else if (pass_fire && count_q != CNT_MAX) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    kp_out_reg #(.COORD_W(COORD_W)) u_kp_out (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (pass_fire),
        .in_x        (cand.x),
        .in_y        (cand.y),
        .in_contrast (cand.contrast),
        .kp          (kp)
    );

endmodule

// File: tb/tb_keypoint_counter.sv
// Self-checking bench for keypoint_counter: directed scenarios plus
// randomized frames checked against a queue-based reference model.
module tb_keypoint_counter;
    import sift_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              frame_start = 1'b0;
    logic              frame_end = 1'b0;
    logic signed [9:0] filter_threshold = '0;
    logic [10:0]       keypoint_num;
    logic              num_valid;

    keypoint_counter_if #(.COORD_W(10)) cand_if ();
    keypoint_counter_if #(.COORD_W(10)) kp_if ();

    keypoint_counter #(.COORD_W(10), .CNT_W(11), .KP_RESET_NUM(750)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .frame_start      (frame_start),
        .frame_end        (frame_end),
        .filter_threshold (filter_threshold),
        .cand             (cand_if),
        .kp               (kp_if),
        .keypoint_num     (keypoint_num),
        .num_valid        (num_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]        x;
        logic [9:0]        y;
        logic signed [9:0] c;
    } kp_t;

    int    tests = 0;
    int    failures = 0;
    kp_t   exp_q[$];
    int    model_thr = 0;
    int    model_count = 0;
    int    kp_xfers = 0;
    int    nv_count = 0;
    logic [10:0] nv_value = '0;
    bit    pend = 0;
    kp_t   pend_kp;

    // Reference model: every accepted candidate with |contrast| > latched
    // threshold must appear downstream exactly one cycle later, in order.
    always @(negedge clk) begin
        kp_t e;
        int  c, mag;
        if (!rst_n) begin
            pend = 0;
        end else begin
            if (pend) begin
                tests++;
                if (kp_if.valid !== 1'b1 || kp_if.x !== pend_kp.x ||
                    kp_if.y !== pend_kp.y || kp_if.contrast !== pend_kp.c) begin
                    failures++;
                    $display("FAIL kp_latency: got valid=%b x=%0d y=%0d c=%0d, expected valid=1 x=%0d y=%0d c=%0d",
                             kp_if.valid, kp_if.x, kp_if.y, kp_if.contrast,
                             pend_kp.x, pend_kp.y, pend_kp.c);
                end
            end
            pend = 0;
            if (kp_if.valid && kp_if.ready) begin
                kp_xfers++;
                tests++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL kp_unexpected: got x=%0d y=%0d c=%0d, expected no keypoint",
                             kp_if.x, kp_if.y, kp_if.contrast);
                end else begin
                    e = exp_q.pop_front();
                    if (kp_if.x !== e.x || kp_if.y !== e.y || kp_if.contrast !== e.c) begin
                        failures++;
                        $display("FAIL kp_data: got x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d",
                                 kp_if.x, kp_if.y, kp_if.contrast, e.x, e.y, e.c);
                    end
                end
            end
            if (cand_if.valid && cand_if.ready) begin
                c   = int'(cand_if.contrast);
                mag = (c < 0) ? -c : c;
                if (mag > model_thr) begin
                    e.x = cand_if.x;
                    e.y = cand_if.y;
                    e.c = cand_if.contrast;
                    exp_q.push_back(e);
                    pend    = 1;
                    pend_kp = e;
                    if (model_count < 2047) model_count++;
                end
            end
            if (num_valid) begin
                nv_count++;
                nv_value = keypoint_num;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int thr);
        frame_start      = 1'b1;
        filter_threshold = 10'(thr);
        model_thr        = thr;
        model_count      = 0;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic end_frame();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    task automatic send_cand(input int c, input int x, input int y, input bit with_end);
        bit ok = 0;
        cand_if.valid    = 1'b1;
        cand_if.contrast = 10'(c);
        cand_if.x        = 10'(x);
        cand_if.y        = 10'(y);
        frame_end        = with_end;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cand_if.ready) begin
                ok = 1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            failures++;
            $display("FAIL cand_accept: got no cand_ready in 100 cycles, expected acceptance");
        end
        @(posedge clk);
        #1;
        cand_if.valid = 1'b0;
        frame_end     = 1'b0;
    endtask

    task automatic wait_num(input int exp);
        int start = nv_count;
        bit seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (nv_count != start) begin
                seen = 1;
                break;
            end
        end
        tests++;
        if (!seen) begin
            failures++;
            $display("FAIL num_valid_timeout: got no pulse in 50 cycles, expected keypoint_num=%0d", exp);
        end else begin
            tests++;
            if (nv_value !== 11'(exp)) begin
                failures++;
                $display("FAIL keypoint_num: got %0d, expected %0d", nv_value, exp);
            end
        end
        repeat (4) tick();
        tests++;
        if (nv_count != start + 1 || keypoint_num !== 11'(exp)) begin
            failures++;
            $display("FAIL num_pulse_once: got %0d pulses num=%0d, expected 1 pulse num=%0d",
                     nv_count - start, keypoint_num, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        tests++;
        if (keypoint_num !== 11'd750 || kp_if.valid !== 1'b0 || cand_if.ready !== 1'b0 ||
            num_valid !== 1'b0 || kp_if.x !== 10'd0 || kp_if.contrast !== 10'sd0) begin
            failures++;
            $display("FAIL reset: got num=%0d kp_valid=%b cand_ready=%b num_valid=%b, expected 750/0/0/0",
                     keypoint_num, kp_if.valid, cand_if.ready, num_valid);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_threshold();
        int xs = kp_xfers;
        int cs[5] = '{3, -3, 2, -2, 0};
        kp_if.ready = 1'b1;
        pulse_start(2);
        for (int i = 0; i < 5; i++) send_cand(cs[i], 10 + i, 20 + i, 1'b0);
        end_frame();
        wait_num(2);
        tests++;
        if (kp_xfers - xs != 2) begin
            failures++;
            $display("FAIL thr_emitted: got %0d keypoints, expected 2", kp_xfers - xs);
        end
    endtask

    task automatic test_neg_threshold();
        int xs = kp_xfers;
        pulse_start(-1);
        filter_threshold = 10'sd100;
        for (int i = 0; i < 4; i++) send_cand(0, i, i, 1'b0);
        end_frame();
        wait_num(4);
        tests++;
        if (kp_xfers - xs != 4) begin
            failures++;
            $display("FAIL negthr_emitted: got %0d keypoints, expected 4", kp_xfers - xs);
        end
    endtask

    task automatic test_back_to_back();
        pulse_start(0);
        for (int i = 0; i < 6; i++) send_cand(-512 + i, 1000 - i, i, (i == 5));
        wait_num(6);
    endtask

    task automatic test_stall();
        int start;
        pulse_start(0);
        kp_if.ready      = 1'b0;
        cand_if.valid    = 1'b1;
        cand_if.contrast = 10'sd5;
        cand_if.x        = 10'd1;
        cand_if.y        = 10'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i > 0) begin
                tests++;
                if (cand_if.ready !== 1'b0 || kp_if.valid !== 1'b1 || kp_if.x !== 10'd1 ||
                    kp_if.y !== 10'd2 || kp_if.contrast !== 10'sd5) begin
                    failures++;
                    $display("FAIL stall_hold: got cand_ready=%b kp_valid=%b x=%0d y=%0d c=%0d, expected 0/1/1/2/5",
                             cand_if.ready, kp_if.valid, kp_if.x, kp_if.y, kp_if.contrast);
                end
            end
            @(posedge clk);
            #1;
        end
        cand_if.valid = 1'b0;
        end_frame();
        start = nv_count;
        repeat (3) tick();
        tests++;
        if (nv_count != start || kp_if.valid !== 1'b1) begin
            failures++;
            $display("FAIL drain_wait: got %0d pulses kp_valid=%b, expected 0 pulses kp_valid=1",
                     nv_count - start, kp_if.valid);
        end
        kp_if.ready = 1'b1;
        wait_num(1);
    endtask

    task automatic test_abort();
        int start;
        pulse_start(10);
        for (int i = 0; i < 7; i++) send_cand(50, i, 7, 1'b0);
        start = nv_count;
        pulse_start(10);
        repeat (3) tick();
        tests++;
        if (nv_count != start || keypoint_num !== 11'd1) begin
            failures++;
            $display("FAIL abort: got %0d pulses num=%0d, expected 0 pulses num=1",
                     nv_count - start, keypoint_num);
        end
        for (int i = 0; i < 3; i++) send_cand(-50, i, 9, 1'b0);
        end_frame();
        wait_num(3);
        start = nv_count;
        end_frame();
        repeat (5) tick();
        tests++;
        if (nv_count != start || keypoint_num !== 11'd3) begin
            failures++;
            $display("FAIL idle_frame_end: got %0d pulses num=%0d, expected 0 pulses num=3",
                     nv_count - start, keypoint_num);
        end
    endtask

    task automatic test_saturation();
        pulse_start(0);
        for (int i = 0; i < 2100; i++) send_cand(1 + (i % 500), i % 1024, i / 1024, 1'b0);
        end_frame();
        wait_num(2047);
    endtask

    task automatic test_random();
        bit acc;
        for (int f = 0; f < 4; f++) begin
            pulse_start(int'($urandom_range(0, 70)) - 10);
            cand_if.valid = 1'b0;
            for (int i = 0; i < 150; i++) begin
                @(negedge clk);
                acc = cand_if.valid && cand_if.ready;
                @(posedge clk);
                #1;
                if (acc || !cand_if.valid) begin
                    cand_if.valid    = ($urandom_range(0, 3) != 0);
                    cand_if.contrast = 10'($urandom_range(0, 1023));
                    cand_if.x        = 10'($urandom_range(0, 1023));
                    cand_if.y        = 10'($urandom_range(0, 1023));
                end
                kp_if.ready = ($urandom_range(0, 2) != 0);
            end
            cand_if.valid = 1'b0;
            end_frame();
            kp_if.ready = 1'b1;
            wait_num(model_count);
        end
    endtask

    task automatic test_reset_midframe();
        pulse_start(0);
        kp_if.ready = 1'b0;
        send_cand(9, 3, 4, 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        model_count = 0;
        repeat (2) tick();
        tests++;
        if (kp_if.valid !== 1'b0 || keypoint_num !== 11'd750 || cand_if.ready !== 1'b0 ||
            num_valid !== 1'b0 || kp_if.x !== 10'd0) begin
            failures++;
            $display("FAIL reset_midframe: got kp_valid=%b num=%0d cand_ready=%b, expected 0/750/0",
                     kp_if.valid, keypoint_num, cand_if.ready);
        end
        rst_n = 1'b1;
        kp_if.ready = 1'b1;
        repeat (3) tick();
        tests++;
        if (kp_if.valid !== 1'b0 || keypoint_num !== 11'd750) begin
            failures++;
            $display("FAIL post_reset_idle: got kp_valid=%b num=%0d, expected 0/750",
                     kp_if.valid, keypoint_num);
        end
    endtask

    initial begin
        cand_if.valid    = 1'b0;
        cand_if.contrast = '0;
        cand_if.x        = '0;
        cand_if.y        = '0;
        kp_if.ready      = 1'b1;
        test_reset();
        test_threshold();
        test_neg_threshold();
        test_back_to_back();
        test_stall();
        test_abort();
        test_saturation();
        test_random();
        repeat (3) tick();
        tests++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL kp_outstanding: got %0d undelivered keypoints, expected 0", exp_q.size());
        end
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running at 2 ms, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/keypoint_counter.md
Name: keypoint_counter

Overview:
- Producer side of the contrast-threshold feedback loop.
- Receives extremum candidates from the DoG extrema detector and applies the current signed contrast threshold, held fixed for the whole frame.
- Forwards surviving keypoints downstream through a valid/ready register stage.
- At frame end, publishes the 11-bit per-frame keypoint count (keypoint_num) that the threshold controller consumes.

Parameters:
- COORD_W, 10, width of the candidate x/y coordinates.
- CNT_W, 11, width of keypoint_num; the count saturates at 2^CNT_W-1 = 2047.
- KP_RESET_NUM, 750, reset/idle value of keypoint_num; lies between the 500 and 1000 high-throughput bounds so the threshold holds after reset.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, synchronous reset, active-low.
- frame_start, in, 1, one-cycle pulse marking the start of a frame.
- frame_end, in, 1, one-cycle pulse marking the end of a frame.
- filter_threshold, in, 10 signed, contrast threshold; sampled only on an accepted frame_start.
- cand_valid, in, 1, candidate present.
- cand_ready, out, 1, candidate accepted when cand_valid && cand_ready.
- cand_contrast, in, 10 signed, DoG contrast of the candidate.
- cand_x, in, COORD_W, candidate column.
- cand_y, in, COORD_W, candidate row.
- kp_valid, out, 1, keypoint output valid.
- kp_ready, in, 1, downstream ready.
- kp_x, out, COORD_W, keypoint column.
- kp_y, out, COORD_W, keypoint row.
- kp_contrast, out, 10 signed, keypoint contrast.
- keypoint_num, out, CNT_W, keypoint count of the last completed frame.
- num_valid, out, 1, one-cycle pulse when keypoint_num updates.

Behaviour:
- Reset values: state=IDLE, cand_ready=0, kp_valid=0, kp_x/kp_y/kp_contrast=0, keypoint_num=KP_RESET_NUM, num_valid=0, internal count=0, latched threshold=0.
- States: IDLE, COUNT, DRAIN, PUBLISH.
- IDLE:
  - cand_ready=0.
  - On frame_start: latch filter_threshold into thr_q, clear count, go to COUNT.
  - frame_end is ignored.
- COUNT:
  - cand_ready = !kp_valid || kp_ready.
  - Pass test on an accepted candidate: |cand_contrast| > thr_q.
  - |x| is computed as 11-bit unsigned (|-512| = 512); the compare is signed 12-bit so a negative thr_q passes every candidate.
  - A passing candidate loads the kp_* registers and sets kp_valid on the next edge (1-cycle latency). It also increments count, saturating at 2047 (no wrap).
  - A failing candidate is consumed and dropped; count is unchanged.
  - On frame_end, a candidate accepted in the same cycle is still counted. Go to DRAIN if kp_valid will be 1 after this edge, else go to PUBLISH.
  - frame_start without frame_end in COUNT aborts the frame: re-latch the threshold, clear count, stay in COUNT, no publish. keypoint_num keeps its old value. Any kp_valid output already held completes its handshake normally.
  - If frame_start and frame_end arrive in the same cycle, frame_end wins and frame_start is ignored.
- DRAIN:
  - cand_ready=0.
  - Wait until kp_valid && kp_ready, then go to PUBLISH.
  - frame_start and frame_end are ignored.
- PUBLISH (1 cycle):
  - keypoint_num <= count; num_valid=1 for this cycle only.
  - Go to IDLE. frame_start in this cycle is ignored; the upstream guarantees at least 2 idle cycles between frame_end and the next frame_start.
- Output handshake:
  - kp_valid stays asserted and kp_* stay stable until kp_ready.
  - kp_valid clears on the transfer edge unless a new passing candidate is accepted in the same cycle, in which case the registers reload (back-to-back throughput, 1 keypoint/cycle).
- keypoint_num changes only in PUBLISH or on reset.
- Reset mid-frame: all state returns to reset values; any in-flight keypoint is lost.

Decomposition:
- Shared package sift_pkg holds:
  - the state encoding enum,
  - CONTRAST_W=10,
  - COORD_W and CNT_W defaults,
  - the HIGH_THROUGHPUT=0 / HIGH_ACCURACY=1 mode constants shared with the threshold controller.
- One natural sub-module, kp_out_reg: a valid/ready output register for {x, y, contrast} with load/hold/transfer logic. The FSM, abs/compare and saturating counter stay in the top.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> keypoint_num=750, kp_valid=0, cand_ready=0, num_valid=0.
- Threshold 2, frame of 5 candidates with contrast {3, -3, 2, -2, 0}, kp_ready=1 -> 2 keypoints emitted (3, -3), each 1 cycle after acceptance; after frame_end, num_valid pulses once with keypoint_num=2.
- filter_threshold=-1 at frame_start, then changed to 100 mid-frame; 4 candidates with contrast 0 -> all 4 pass (latched threshold used), keypoint_num=4.
- kp_ready=0 for 10 cycles while cand_valid=1 -> exactly 1 keypoint held stable and cand_ready=0 throughout. frame_end during the stall -> DRAIN; num_valid appears only after the kp_valid && kp_ready handshake completes.
- 2100 passing candidates in one frame -> keypoint_num=2047 (saturated, no wrap).
- frame_start pulsed again after 7 passes -> count restarts and no num_valid; the frame then ends with 3 passes -> keypoint_num=3. Also: frame_end in IDLE -> no num_valid and keypoint_num unchanged.
